// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: FSM state type and default sizing
// for the two-port APB request arbiter.
package apb_arb_pkg;

  localparam int ADDR_W_DEF  = 9;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: 2-way round-robin pick.
// Ports: clk, rst_n, req/mask in, en (grant allowed), valid/idx out.
module apb_rr_arbiter
  import apb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       en,
  output logic       valid,
  output logic       idx
);

  // prio = requester that wins a tie
  logic       prio;
  logic [1:0] live;

  assign live  = req & ~mask;
  assign valid = |live;
  assign idx   = (live == 2'b11) ? prio : live[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (en && valid) begin
      prio <= ~idx;
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: grants one APB master core to two requesters.
// Ports: req/wr/addr/wdata per side, ack/err/rdata back, core drive.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              owner,
  output logic              transfer,
  output logic              mpwrite,
  output logic [ADDR_W-1:0] apb_write_paddr,
  output logic [ADDR_W-1:0] apb_read_paddr,
  output logic [DATA_W-1:0] apb_write_data,
  input  logic              psel,
  input  logic              penable,
  input  logic [DATA_W-1:0] apb_read_data_out
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [1:0]        mask;
  logic              gnt_valid;
  logic              gnt_idx;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              at_limit;

  apb_rr_arbiter u_rr (
    .clk   (pclk),
    .rst_n (preset),
    .req   ({req1, req0}),
    .mask  (mask),
    .en    (state == IDLE),
    .valid (gnt_valid),
    .idx   (gnt_idx)
  );

  assign sel_wr    = gnt_idx ? wr1 : wr0;
  assign sel_addr  = gnt_idx ? addr1 : addr0;
  assign sel_wdata = gnt_idx ? wdata1 : wdata0;
  assign at_limit  = (cnt == CW'(TIMEOUT));
  assign busy      = (state != IDLE);

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state           <= IDLE;
      cnt             <= '0;
      mask            <= '0;
      owner           <= 1'b0;
      ack0            <= 1'b0;
      ack1            <= 1'b0;
      err             <= 1'b0;
      rdata           <= '0;
      transfer        <= 1'b0;
      mpwrite         <= 1'b0;
      apb_write_paddr <= '0;
      apb_read_paddr  <= '0;
      apb_write_data  <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      unique case (state)
        IDLE: begin
          // mask only lives for the IDLE cycle right after DONE
          mask <= '0;
          if (gnt_valid) begin
            state           <= ISSUE;
            owner           <= gnt_idx;
            transfer        <= 1'b1;
            mpwrite         <= sel_wr;
            apb_write_paddr <= sel_wr ? sel_addr : '0;
            apb_read_paddr  <= sel_wr ? '0 : sel_addr;
            apb_write_data  <= sel_wdata;
            cnt             <= '0;
          end
        end
        ISSUE: begin
          cnt   <= cnt + 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (psel && penable) begin
            if (!mpwrite) rdata <= apb_read_data_out;
            err      <= 1'b0;
            transfer <= 1'b0;
            ack0     <= ~owner;
            ack1     <= owner;
            state    <= DONE;
          end else if (at_limit) begin
            err      <= 1'b1;
            transfer <= 1'b0;
            ack0     <= ~owner;
            ack1     <= owner;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          mask  <= owner ? 2'b10 : 2'b01;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: vectors, corner sequences and a
// randomized transaction-level model with an APB core stub.
module tb_apb_req_arbiter;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          preset = 1'b0;
  logic          req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err, busy, owner, transfer, mpwrite;
  logic [DW-1:0] rdata, apb_write_data;
  logic [DW-1:0] apb_read_data_out = '0;
  logic [AW-1:0] apb_write_paddr, apb_read_paddr;
  logic          psel, penable;
  logic          stall = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk              (pclk),
    .preset            (preset),
    .req0              (req0),
    .req1              (req1),
    .wr0               (wr0),
    .wr1               (wr1),
    .addr0             (addr0),
    .addr1             (addr1),
    .wdata0            (wdata0),
    .wdata1            (wdata1),
    .ack0              (ack0),
    .ack1              (ack1),
    .err               (err),
    .rdata             (rdata),
    .busy              (busy),
    .owner             (owner),
    .transfer          (transfer),
    .mpwrite           (mpwrite),
    .apb_write_paddr   (apb_write_paddr),
    .apb_read_paddr    (apb_read_paddr),
    .apb_write_data    (apb_write_data),
    .psel              (psel),
    .penable           (penable),
    .apb_read_data_out (apb_read_data_out)
  );

  // core stub: SETUP the cycle after transfer, ACCESS the next
  always @(posedge pclk or negedge preset) begin
    if (!preset) begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end else if (!transfer) begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end else if (!psel) begin
      psel <= 1'b1;
    end else if (!stall) begin
      penable <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {ack0, ack1, err, busy, owner, transfer, mpwrite,
            rdata, apb_write_data, 1'b0} ^
           {23'd0, apb_write_paddr} ^ {23'd0, apb_read_paddr};
  endfunction

  function automatic logic [31:0] outs_or();
    return {31'd0, (|{ack0, ack1, err, busy, owner, transfer, mpwrite,
                      rdata, apb_write_data, apb_write_paddr,
                      apb_read_paddr})};
  endfunction

  task automatic do_reset();
    req0 = 0; req1 = 0; stall = 0;
    preset = 1'b0;
    repeat (2) @(negedge pclk);
    chk("reset_outs", outs_or(), 32'd0);
    preset = 1'b1;
    @(negedge pclk);
  endtask

  typedef struct {
    logic          sel;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] core;
    logic          hang;
    int            ack_cyc;
    logic          err;
    logic [DW-1:0] rdata;
  } vec_t;

  task automatic run_vec(input vec_t v, input int n);
    int            ack_at = 0;
    int            xfer = 0;
    logic [31:0]   core_exp;
    logic [AW-1:0] wpa, rpa;
    wpa = v.wr ? v.addr : '0;
    rpa = v.wr ? '0 : v.addr;
    core_exp = {5'd0, v.wr, wpa, rpa, v.wd};
    stall = v.hang;
    apb_read_data_out = v.core;
    if (v.sel) begin
      req1 = 1; wr1 = v.wr; addr1 = v.addr; wdata1 = v.wd;
    end else begin
      req0 = 1; wr0 = v.wr; addr0 = v.addr; wdata0 = v.wd;
    end
    for (int c = 1; c <= 40 && ack_at == 0; c++) begin
      @(negedge pclk);
      if (transfer) xfer++;
      if (c == 1)
        chk($sformatf("v%0d_core", n),
            {5'd0, mpwrite, apb_write_paddr, apb_read_paddr,
             apb_write_data}, core_exp);
      if (ack0 || ack1) begin
        ack_at = c;
        chk($sformatf("v%0d_ackidx", n), {30'd0, ack1, ack0},
            v.sel ? 32'd2 : 32'd1);
        chk($sformatf("v%0d_err", n), {31'd0, err}, {31'd0, v.err});
        chk($sformatf("v%0d_rdata", n), {24'd0, rdata}, {24'd0, v.rdata});
        chk($sformatf("v%0d_owner", n), {31'd0, owner}, {31'd0, v.sel});
      end
    end
    req0 = 0; req1 = 0;
    chk($sformatf("v%0d_ackcyc", n), ack_at, v.ack_cyc);
    chk($sformatf("v%0d_xfer", n), xfer, v.ack_cyc - 1);
    repeat (3) @(negedge pclk);
    stall = 0;
  endtask

  vec_t vecs[6];

  // random-phase model state
  logic [1:0]    a1, a2, req_prev, live;
  logic          tr_prev, winner, win_wr, exp_err, last_served, exp_w;
  logic [DW-1:0] model_rdata, cur_core;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wd;
  int            wait0, wait1, age0, age1;

  task automatic stim(input int i, input logic acked);
    if (i == 0) begin
      if (acked) begin
        req0 = 0; wait0 = $urandom_range(0, 3);
      end else if (!req0) begin
        if (wait0 > 0) wait0--;
        else if ($urandom_range(0, 1) == 1) begin
          req0 = 1; wr0 = 1'($urandom);
          addr0 = AW'($urandom); wdata0 = DW'($urandom);
        end
      end
    end else begin
      if (acked) begin
        req1 = 0; wait1 = $urandom_range(0, 3);
      end else if (!req1) begin
        if (wait1 > 0) wait1--;
        else if ($urandom_range(0, 1) == 1) begin
          req1 = 1; wr1 = 1'($urandom);
          addr1 = AW'($urandom); wdata1 = DW'($urandom);
        end
      end
    end
  endtask

  initial begin
    int order[$];
    int ack_cyc[$];
    int n0, n1, acks, got1, ackc;

    vecs[0] = '{0, 1, 9'h005, 8'hA5, 8'h00, 0, 4, 0, 8'h00};
    vecs[1] = '{1, 0, 9'h010, 8'h11, 8'h3C, 0, 4, 0, 8'h3C};
    vecs[2] = '{0, 0, 9'h1FF, 8'h22, 8'h81, 0, 4, 0, 8'h81};
    vecs[3] = '{1, 1, 9'h100, 8'h5A, 8'hC3, 0, 4, 0, 8'h81};
    vecs[4] = '{0, 0, 9'h07E, 8'h44, 8'hEE, 1, TO + 2, 1, 8'h81};
    vecs[5] = '{0, 1, 9'h0AA, 8'h33, 8'h99, 0, 4, 0, 8'h81};

    do_reset();
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // both requesters held: strict alternation, 5-cycle spacing
    do_reset();
    req0 = 1; wr0 = 0; addr0 = 9'h021; apb_read_data_out = 8'h5E;
    req1 = 1; wr1 = 1; addr1 = 9'h042; wdata1 = 8'h7F;
    for (int c = 1; c <= 80 && order.size() < 4; c++) begin
      @(negedge pclk);
      if (ack0 && ack1) chk("rr_both_ack", 32'd1, 32'd0);
      if (ack0) begin order.push_back(0); ack_cyc.push_back(c); end
      if (ack1) begin order.push_back(1); ack_cyc.push_back(c); end
    end
    req0 = 0; req1 = 0;
    chk("rr_nacks", order.size(), 4);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_order%0d", i),
          (i < order.size()) ? order[i] : 99, i % 2);
      if (i < order.size()) begin
        if (order[i] == 0) n0++; else n1++;
      end
    end
    chk("rr_cnt0", n0, 2);
    chk("rr_cnt1", n1, 2);
    chk("rr_first_cyc", (ack_cyc.size() > 0) ? ack_cyc[0] : 0, 4);
    for (int i = 1; i < 4; i++)
      chk($sformatf("rr_gap%0d", i),
          (i < ack_cyc.size()) ? ack_cyc[i] - ack_cyc[i-1] : 0, 5);
    repeat (3) @(negedge pclk);

    // async reset in WAIT
    do_reset();
    req0 = 1; wr0 = 0; addr0 = 9'h033; apb_read_data_out = 8'h77;
    stall = 1;
    repeat (3) @(negedge pclk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    req1 = 1; wr1 = 1; addr1 = 9'h044; wdata1 = 8'h99;
    #2 preset = 1'b0;
    #1 chk("async_rst_outs", outs_or(), 32'd0);
    acks = 0;
    repeat (3) begin
      @(negedge pclk);
      if (ack0 || ack1) acks++;
    end
    chk("rst_no_ack", acks, 0);
    req0 = 0; stall = 0;
    preset = 1'b1;
    got1 = 0; ackc = 0;
    for (int c = 1; c <= 20 && ackc == 0; c++) begin
      @(negedge pclk);
      if (ack0) chk("post_rst_ack0", 32'd1, 32'd0);
      if (ack1) begin
        ackc = c;
        chk("post_rst_owner", {31'd0, owner}, 32'd1);
        chk("post_rst_err", {31'd0, err}, 32'd0);
        chk("post_rst_rdata", {24'd0, rdata}, 32'd0);
      end
    end
    chk("post_rst_ackcyc", ackc, 4);
    req1 = 0;
    repeat (3) @(negedge pclk);

    // randomized traffic vs transaction-level model
    do_reset();
    a1 = 0; a2 = 0; req_prev = 0; tr_prev = 0;
    last_served = 1; winner = 0; win_wr = 0; exp_err = 0;
    model_rdata = 0; cur_core = 0; wait0 = 0; wait1 = 0;
    age0 = 0; age1 = 0; win_addr = 0; win_wd = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge pclk);
      if (ack0 && ack1) chk("rnd_both_ack", 32'd1, 32'd0);
      if (transfer && !tr_prev) begin
        // requester acked just before this grant may not win it
        live = req_prev & ~a2;
        chk("rnd_grant_live", {31'd0, live != 2'b00}, 32'd1);
        exp_w = (live == 2'b11) ? ~last_served : live[1];
        chk("rnd_owner", {31'd0, owner}, {31'd0, exp_w});
        winner = exp_w;
        last_served = exp_w;
        win_wr   = exp_w ? wr1 : wr0;
        win_addr = exp_w ? addr1 : addr0;
        win_wd   = exp_w ? wdata1 : wdata0;
        chk("rnd_core",
            {5'd0, mpwrite, apb_write_paddr, apb_read_paddr,
             apb_write_data},
            {5'd0, win_wr, win_wr ? win_addr : 9'd0,
             win_wr ? 9'd0 : win_addr, win_wd});
        cur_core = DW'($urandom);
        apb_read_data_out = cur_core;
        stall = ($urandom_range(0, 7) == 0);
        exp_err = stall;
      end
      if (ack0 || ack1) begin
        chk("rnd_ackidx", {31'd0, ack1}, {31'd0, winner});
        chk("rnd_err", {31'd0, err}, {31'd0, exp_err});
        if (!win_wr && !exp_err) model_rdata = cur_core;
        chk("rnd_rdata", {24'd0, rdata}, {24'd0, model_rdata});
      end
      if (req0) age0++; else age0 = 0;
      if (req1) age1++; else age1 = 0;
      if (age0 > 60) begin chk("rnd_starve0", age0, 0); age0 = 0; end
      if (age1 > 60) begin chk("rnd_starve1", age1, 0); age1 = 0; end
      a2 = a1;
      a1 = {ack1, ack0};
      tr_prev = transfer;
      stim(0, ack0);
      stim(1, ack1);
      req_prev = {req1, req0};
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Two-port request arbiter and sequencer in front of one `top_amba_apb` master core. It accepts single read or write transactions from two independent requesters and grants the core to one at a time with round-robin fairness. It drives the core's `transfer`/`mpwrite`/address/data inputs and tracks the core's `psel`/`penable` to detect completion. It returns a one-cycle acknowledge, read data and a timeout error flag to the winning requester.

## Interface
- `ADDR_W`, 9, address width of requester and core address buses
- `DATA_W`, 8, data width
- `TIMEOUT`, 16, maximum cycles from transfer assertion to access phase before abort (≥4)

- `pclk`  in  1  clock
- `preset`  in  1  reset; asynchronous, active-low
- `req0`, `req1`  in  1  transaction request, held until matching ack
- `wr0`, `wr1`  in  1  1 = write, 0 = read; stable while req high
- `addr0`, `addr1`  in  ADDR_W  transaction address; stable while req high
- `wdata0`, `wdata1`  in  DATA_W  write data; stable while req high
- `ack0`, `ack1`  out  1  one-cycle completion pulse
- `err`  out  1  valid with ack; 1 = timeout abort
- `rdata`  out  DATA_W  read data; valid with ack, held until next ack
- `busy`  out  1  high in any state except IDLE
- `owner`  out  1  index of current/last granted requester
- `transfer`  out  1  to core: start/continue transfer
- `mpwrite`  out  1  to core: write select
- `apb_write_paddr`, `apb_read_paddr`  out  ADDR_W  to core: write/read address
- `apb_write_data`  out  DATA_W  to core: write data
- `psel`, `penable`  in  1  from core: APB phase indicators
- `apb_read_data_out`  in  DATA_W  from core: read data

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample `req0`/`req1`. If both are high, grant the requester not served last; after reset requester 0 wins. On grant, latch wr/addr/wdata into internal registers, set `owner`, and go to ISSUE.
- The requester acked in the previous DONE is masked for the first IDLE cycle, so a stale req is never re-granted.
- ISSUE: `transfer`=1, core inputs driven from latched fields. Unused address bus = 0. Go to WAIT.
- WAIT: `transfer` held 1.
  - When `psel && penable` is sampled high: capture `apb_read_data_out` into `rdata` (reads only; writes leave `rdata` unchanged), `err`=0, go to DONE.
  - When the timeout counter reaches TIMEOUT first: `err`=1, `rdata` unchanged, go to DONE.
- DONE: `transfer`=0, pulse `ack<owner>` for one cycle, go to IDLE.
- Timeout counter: clears on ISSUE entry and saturates at TIMEOUT. Width is $clog2(TIMEOUT+1).
- A requester dropping req mid-transaction does not cancel it; the ack still pulses.

## Timing
- Reset (`preset`=0, asynchronous):
  - State IDLE, priority pointer = requester 0, mask cleared, counter 0.
  - All outputs 0, including `rdata`, `owner`, `err` and the core inputs.
- Assumed core behaviour: SETUP the cycle after `transfer` rises, ACCESS the cycle after that.
- With that core: req seen at edge 0 → ISSUE in cycle 1, psel in cycle 2, psel&penable in cycle 3, ack in cycle 4.
- Minimum spacing between grants is 5 cycles (DONE → IDLE → grant).
- Core inputs are registered outputs and stay constant from ISSUE through DONE.
- `busy` is high in ISSUE/WAIT/DONE. `ack0` and `ack1` are never high together.

## Structure
- Package `apb_arb_pkg`: state enum (IDLE, ISSUE, WAIT, DONE) and default width/timeout constants.
- Sub-module `apb_rr_arbiter`: 2-way round-robin pick from requests, mask and last-owner pointer. It is combinational select plus a registered pointer updated on grant.
- Top `apb_req_arbiter`: FSM, field latches, timeout counter, output registers.

## Test plan
- Single write: req0, wr0=1, addr0=0x05, wdata0=0xA5. Required: `transfer` high cycles 1-3, `mpwrite`=1, `apb_write_paddr`=0x05, `apb_write_data`=0xA5, `ack0` in cycle 4, `err`=0.
- Single read: req1, addr1=0x10, core returns 0x3C at access. Required: `ack1` with `rdata`=0x3C, `mpwrite`=0, `owner`=1.
- Simultaneous requests, both held: grants alternate 0,1,0,1 across four transactions; each requester is acked exactly twice.
- Timeout: core stub never raises penable. Required: `ack0` with `err`=1 after TIMEOUT=16 WAIT cycles, `rdata` unchanged, next request served normally.
- Async reset asserted mid-WAIT: all outputs 0 immediately, no ack issued. After release, a pending req1 is granted only after priority resets to 0 with no req0 present.
